// File: rtl/mux_nx1_pipe_pkg.sv
// Shared definitions for the N-to-1 registered word multiplexer: mode codes,
// output-register state encoding and a width helper.
package mux_nx1_pipe_pkg;

  localparam logic MUX_MODE_SEL = 1'b0;
  localparam logic MUX_MODE_RR  = 1'b1;

  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/mux_nx1_pipe_rr.sv
// Combinational round-robin priority finder: first requester after 'last',
// scanning upward and wrapping from N-1 to 0.
module rr_grant_n
  import mux_nx1_pipe_pkg::*;
#(
  parameter int unsigned N  = 3,
  parameter int unsigned CW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] last,
  output logic [CW-1:0] gnt_idx,
  output logic          gnt_any
);

  int unsigned idx;

  // Scan from farthest to nearest so the nearest requester is written last.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int unsigned k = N; k >= 1; k--) begin
      idx = (32'(last) + k) % N;
      if ((req & (N'(1) << idx)) != '0) begin
        gnt_idx = CW'(idx);
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_nx1_pipe.sv
// N-to-1 word multiplexer with one registered output stage and valid/ready
// handshakes; explicit select or fair round-robin arbitration.
module mux_nx1_pipe
  import mux_nx1_pipe_pkg::*;
#(
  parameter int unsigned W  = 8,
  parameter int unsigned N  = 3,
  parameter int unsigned CW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mode,
  input  logic [CW-1:0]  ctrl,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [CW-1:0]  out_chan,
  input  logic           out_ready,
  output logic           err_sel
);

  if (N < 2 || N > 16 || CW < clog2(N)) begin : g_bad_param
    $error("mux_nx1_pipe: N must be 2..16 and 2**CW >= N");
  end

  state_e        state_q, state_d;
  logic [W-1:0]  data_q, data_d;
  logic [CW-1:0] chan_q, chan_d;
  logic [CW-1:0] last_q, last_d;
  logic          err_q, err_d;

  logic [CW-1:0] rr_idx;
  logic          rr_any;
  logic          ctrl_in_range;
  logic          sel_any;
  logic [CW-1:0] gnt_idx;
  logic          gnt_any;
  logic          can_load;
  logic          load;

  rr_grant_n #(
    .N  (N),
    .CW (CW)
  ) u_rr (
    .req     (in_valid),
    .last    (last_q),
    .gnt_idx (rr_idx),
    .gnt_any (rr_any)
  );

  assign ctrl_in_range = 32'(ctrl) < N;
  assign sel_any       = ctrl_in_range && ((in_valid & (N'(1) << ctrl)) != '0);

  always_comb begin
    gnt_idx  = ctrl;
    gnt_any  = sel_any;
    if (mode == MUX_MODE_RR) begin
      gnt_idx = rr_idx;
      gnt_any = rr_any;
    end
    // Reset blocks handshakes so nothing is consumed during the reset cycle.
    can_load = !rst && ((state_q == StEmpty) || out_ready);
    load     = gnt_any && can_load;
    in_ready = load ? (N'(1) << gnt_idx) : '0;
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    chan_d  = chan_q;
    last_d  = last_q;
    err_d   = (mode == MUX_MODE_SEL) && !ctrl_in_range && (in_valid != '0);
    if (load) begin
      state_d = StFull;
      data_d  = W'(in_data >> (32'(gnt_idx) * W));
      chan_d  = gnt_idx;
      if (mode == MUX_MODE_RR) last_d = gnt_idx;
    end else if (state_q == StFull && out_ready) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      data_q  <= '0;
      chan_q  <= '0;
      last_q  <= CW'(N - 1);
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = (state_q == StFull);
  assign out_data  = data_q;
  assign out_chan  = chan_q;
  assign err_sel   = err_q;

endmodule

// File: doc/mux_nx1_pipe.md
Name: mux_nx1_pipe

Overview:
Parametrised N-to-1 word multiplexer with a registered output stage and valid/ready handshakes on every input channel and on the output. It replaces the fixed 3-input combinational selector in the linearizer/normalizer float-to-fixed path. It supports two modes:
- explicit select by control code;
- fair round-robin among valid channels.
Data is delivered with one-cycle latency and full throughput under backpressure.

Parameters:
W, 8, data word width in bits
N, 3, number of input channels (2..16)
CW, 2, control/channel-index width; must satisfy 2**CW >= N

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
mode  in  1  0 = explicit select by ctrl, 1 = round-robin
ctrl  in  CW  channel select code, used when mode=0
in_valid  in  N  per-channel valid; bit i belongs to channel i
in_data  in  N*W  packed channel words; channel i at bits [i*W +: W]
in_ready  out  N  per-channel ready, one-hot or zero
out_valid  out  1  output word valid
out_data  out  W  selected word
out_chan  out  CW  index of the channel that produced out_data
out_ready  in  1  downstream ready
err_sel  out  1  one-cycle pulse: mode=0 and ctrl >= N while in_valid != 0

Behaviour:
- One clock; reset is synchronous and active-high on rst.
- Reset values:
  - out_valid = 0, out_data = 0, out_chan = 0, err_sel = 0.
  - Round-robin pointer last = N-1, so channel 0 wins first.
  - State = EMPTY.
- Output register states:
  - EMPTY: output register holds no word.
  - FULL: output register holds a word.
- can_load = (state == EMPTY) || out_ready.
- Grant g, combinational:
  - mode=0: g = ctrl if ctrl < N and in_valid[ctrl] = 1; otherwise no grant.
  - mode=1: g = first i with in_valid[i] = 1, scanning last+1, last+2, ... modulo N (wrap from N-1 to 0); no grant if in_valid = 0.
- in_ready[g] = can_load when a grant exists; all other in_ready bits are 0. Never more than one in_ready bit is high.
- Load, when a grant exists and can_load:
  - out_data <= in_data[g], out_chan <= g, out_valid <= 1, state = FULL.
  - In mode=1 only, last <= g.
- Drain: FULL and out_ready with no load -> out_valid <= 0, state = EMPTY. out_data and out_chan keep their last value.
- Simultaneous drain and load in the same cycle -> the new word replaces the old one. out_valid stays 1, so throughput is 1 word/cycle.
- FULL and !out_ready -> out_data, out_valid and out_chan are stable, and all in_ready bits are 0.
- Latency: input handshake in cycle t -> word on out_data in cycle t+1.
- ctrl >= N in mode=0: behaves like the 3x1 default branch (no channel passed), nothing is loaded, and err_sel is registered high for one cycle if any in_valid bit is set.
- mode or ctrl may change any cycle. They only affect grants from that cycle onward; the held word is untouched. The pointer is not reset on a mode change.
- rst asserted while FULL drops the held word; no handshake completes in the reset cycle.

Decomposition:
- Shared package (linealizador common):
  - MUX_MODE_SEL = 1'b0, MUX_MODE_RR = 1'b1.
  - State encoding: EMPTY = 1'b0, FULL = 1'b1.
  - clog2 helper function for CW checking.
- One sub-module: rr_grant_n, a combinational round-robin priority finder.
  - Parameters: N, CW.
  - Inputs: req[N], last[CW].
  - Outputs: gnt_idx[CW], gnt_any.

Test Plan:
1. W=8, N=3, mode=0, ctrl=1, in_valid=3'b111, data {0x33,0x22,0x11}, out_ready=1 -> in_ready=3'b010; next cycle out_valid=1, out_data=0x22, out_chan=1; then one word per cycle.
2. mode=0, ctrl=3, in_valid=3'b001 -> in_ready=0, out_valid stays 0, err_sel pulses 1 for exactly one cycle after each such cycle.
3. mode=1, in_valid=3'b111 held, out_ready=1, from reset -> out_chan sequence 0,1,2,0,1; with in_valid=3'b101 -> 0,2,0,2.
4. Backpressure: load 0xA5, out_ready=0 for 4 cycles -> out_data=0xA5 stable, in_ready=0; out_ready=1 -> next word loaded in the same cycle as the drain, no bubble.
5. rst pulsed one cycle while FULL with 0x5A -> next cycle out_valid=0, out_data=0, pointer reset so round-robin grants channel 0 first.
6. Mode switch 1->0 mid-stream with ctrl=2 while the held word is from channel 1 -> held word delivered unchanged, and subsequent out_chan values are all 2.
